cmd_deframer: RTL
=================

CMD_DEFRAMER -- requirements
Module: cmd_deframer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth in 32-bit words (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1000, maximum idle clocks between bytes inside a frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  incoming byte from the serial link receiver.
REQ-006 SHALL have port rx_valid  input  1  rx_data is valid this cycle.
REQ-007 SHALL have port rx_ready  output  1  block accepts the byte this cycle; a byte transfers when rx_valid and rx_ready are both high.
REQ-008 SHALL have port cmd_data  output  32  head FIFO word, show-ahead; 32'd0 when the FIFO is empty.
REQ-009 SHALL have port cmd_waitreq  output  1  high when the FIFO is empty; low when cmd_data is valid.
REQ-010 SHALL have port cmd_rdreq  input  1  pop the head word at this edge.
REQ-011 SHALL have port frame_cnt  output  16  count of good frames pushed, wrapping.
REQ-012 SHALL have port err_cnt  output  8  count of dropped frames (checksum or timeout), saturating at 255.
REQ-013 SHALL have port err_pulse  output  1  one-cycle pulse per dropped frame.

Function
REQ-014 Frame format SHALL be: sync byte 0xA5, four data bytes MSB first (B3,B2,B1,B0), one checksum byte equal to B3^B2^B1^B0.
REQ-015 FSM SHALL have the states S_SYNC, S_DATA and S_CSUM.
REQ-016 In S_SYNC, an accepted 0xA5 SHALL move the FSM to S_DATA with byte index 0; any other accepted byte SHALL be discarded silently, with no error.
REQ-017 In S_DATA, each accepted byte SHALL be shifted into the 32-bit assembly register; after the 4th byte the FSM SHALL move to S_CSUM.
REQ-018 In S_CSUM, on an accepted byte: if it matches the checksum, the assembled word SHALL be written to the FIFO at that edge and frame_cnt SHALL increment; otherwise the word SHALL be dropped, err_pulse SHALL assert for one cycle and err_cnt SHALL increment. In both cases the FSM SHALL return to S_SYNC.
REQ-019 A byte equal to 0xA5 in S_DATA or S_CSUM SHALL be treated as data or checksum, not as a resync.
REQ-020 In S_DATA or S_CSUM, a byte gap counter SHALL clear on each accepted byte and increment otherwise. On reaching TIMEOUT the frame SHALL be dropped, err_pulse asserted, err_cnt incremented, and the FSM returned to S_SYNC.
REQ-021 rx_ready SHALL be low only in S_SYNC while the FIFO is full. Because a frame starts only with a free slot and this block is the only writer, a completed frame SHALL never overflow the FIFO.
REQ-022 The write latency SHALL be one cycle: a word written at edge N into an empty FIFO drives cmd_waitreq low and cmd_data valid after edge N.
REQ-023 cmd_rdreq while cmd_waitreq is high SHALL be ignored, with no pointer change and no error.
REQ-024 A simultaneous push and pop SHALL both take effect, leaving occupancy unchanged. When occupancy is 1, the pushed word SHALL become the head after the edge.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH. Occupancy SHALL be tracked in a counter of width log2(DEPTH)+1.
REQ-026 Words SHALL exit the FIFO in write order, with no reordering and no duplication.
REQ-027 err_cnt SHALL hold at 255 once reached; frame_cnt SHALL wrap from 0xFFFF to 0.

Reset
REQ-028 While rst is high at a clock edge: the FSM SHALL go to S_SYNC; the FIFO SHALL be emptied (cmd_waitreq=1, cmd_data=0); frame_cnt=0, err_cnt=0, err_pulse=0; the gap counter and the assembly register SHALL clear.
REQ-029 rx_ready SHALL be 1 during and after reset, because the FIFO is empty.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no error count. The next byte after reset SHALL be parsed from S_SYNC.

Verification
REQ-031 Bench SHALL cover: bytes A5 12 34 56 78 08 -> cmd_waitreq falls the cycle after the checksum byte, cmd_data=0x12345678, frame_cnt=1; one cmd_rdreq -> cmd_waitreq=1, cmd_data=0.
REQ-032 Bench SHALL cover: bytes A5 12 34 56 78 09 -> no push, err_pulse for one cycle, err_cnt=1; then a following good frame A5 00 00 00 01 01 -> cmd_data=0x00000001.
REQ-033 Bench SHALL cover: bytes 00 FF A5 DE AD then an idle gap of TIMEOUT cycles -> err_cnt=1, FSM back in S_SYNC; leading 00 FF cause no error.
REQ-034 Bench SHALL cover: 5 good frames with DEPTH=4 and no pops -> 4 words stored, rx_ready=0 after the 4th frame, no bytes lost; one pop -> rx_ready=1 and the 5th frame is stored; pop order matches send order.
REQ-035 Bench SHALL cover: occupancy 1 and cmd_rdreq on the same edge as a checksum-byte push -> occupancy stays 1 and cmd_data equals the new word.
REQ-036 Bench SHALL cover: rst pulsed after A5 11 22 -> cmd_waitreq=1, err_cnt=0; then A5 11 22 33 44 44 -> cmd_data=0x11223344.

Source files
------------

// File: rtl/cmd_deframer.sv
// Byte-stream command deframer: parses A5-synced, XOR-checksummed 4-byte frames
// into a show-ahead word FIFO, with inter-byte timeout and good/bad frame counters.
module cmd_deframer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] cmd_data,
  output logic        cmd_waitreq,
  input  logic        cmd_rdreq,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic        err_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {S_SYNC, S_DATA, S_CSUM} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     asm_q, asm_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [15:0]     frame_cnt_q;
  logic [7:0]      err_cnt_q;
  logic            err_pulse_q;

  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            rx_fire, push, drop, pop, empty, full;
  logic [7:0]      csum;
  logic            gap_expired;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  // Only stall between frames: a frame is started only with a free slot.
  assign rx_ready    = !((state_q == S_SYNC) && full);
  assign rx_fire     = rx_valid && rx_ready;
  assign pop         = cmd_rdreq && !empty;
  assign csum        = asm_q[31:24] ^ asm_q[23:16] ^ asm_q[15:8] ^ asm_q[7:0];
  assign gap_expired = (gap_q == GW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    gap_d   = gap_q;
    push    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_SYNC: begin
        gap_d = '0;
        if (rx_fire && (rx_data == SYNC_BYTE)) begin
          state_d = S_DATA;
          idx_d   = 2'd0;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          asm_d = {asm_q[23:0], rx_data};
          gap_d = '0;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_CSUM;
        end else if (gap_expired) begin
          drop    = 1'b1;
          gap_d   = '0;
          state_d = S_SYNC;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_CSUM: begin
        if (rx_fire) begin
          push    = (rx_data == csum);
          drop    = (rx_data != csum);
          gap_d   = '0;
          state_d = S_SYNC;
        end else if (gap_expired) begin
          drop    = 1'b1;
          gap_d   = '0;
          state_d = S_SYNC;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_SYNC;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC;
      idx_q       <= '0;
      asm_q       <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      gap_q       <= gap_d;
      err_pulse_q <= drop;
      if (push) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= asm_q;
  end

  assign cmd_data    = empty ? 32'd0 : mem_q[rd_ptr_q];
  assign cmd_waitreq = empty;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign err_pulse   = err_pulse_q;

endmodule
